regfile_scoreboard: RTL and testbench

- Parametrised successor to the 8x32 core register file.
- Adds configurable width and depth, a hardwired-zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard with an outstanding-writes counter.
- Sits between the decode/issue stage and writeback of the RISC-V pipeline.
- Decode uses it to read operands and to detect RAW and WAW hazards.

---
 rtl/rf_pkg.sv | 8 +
 rtl/rf_scoreboard.sv | 82 ++++++++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_scoreboard.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file with busy scoreboard.
package rf_pkg;
    localparam int D_BITS_DEF = 32;
    localparam int A_BITS_DEF = 3;
    localparam int N_REGS     = 2 ** A_BITS_DEF;
    // Index of the hardwired-zero register when that option is enabled.
    localparam int ZERO_IDX   = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one pending-write bit per register, issue acceptance and
// an outstanding-writes counter that always equals popcount(busy).
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int A_BITS   = A_BITS_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [A_BITS-1:0] src_op0,
    input  logic [A_BITS-1:0] src_op1,
    input  logic              we,
    input  logic [A_BITS-1:0] addr_w,
    input  logic              iss_valid,
    input  logic [A_BITS-1:0] iss_rd,
    output logic              busy_op0,
    output logic              busy_op1,
    output logic              iss_ready,
    output logic [A_BITS:0]   pend_cnt
);
    localparam int              NREGS = 2 ** A_BITS;
    localparam logic [A_BITS-1:0] ZADDR = A_BITS'(ZERO_IDX);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [A_BITS:0]  pend_cnt_q, pend_cnt_d;
    logic             wr_eff, iss_zero, iss_set, inc, dec;

    // Busy view for a read port: zero register never busy, same-cycle
    // writeback hides the bit when forwarding is enabled.
    function automatic logic rd_busy(input logic [A_BITS-1:0] src,
                                     input logic [NREGS-1:0]  bv,
                                     input logic              w,
                                     input logic [A_BITS-1:0] wa);
        if ((ZERO_REG != 0) && (src == ZADDR))
            return 1'b0;
        if ((BYPASS != 0) && w && (wa == src))
            return 1'b0;
        return bv[src];
    endfunction

    // Next busy state, issue handshake and counter delta.
    always_comb begin
        wr_eff    = we && !((ZERO_REG != 0) && (addr_w == ZADDR));
        iss_zero  = (ZERO_REG != 0) && (iss_rd == ZADDR);
        iss_ready = iss_valid && (iss_zero || !busy_q[iss_rd] || (we && (addr_w == iss_rd)));
        iss_set   = iss_ready && !iss_zero;

        busy_d = busy_q;
        if (wr_eff)
            busy_d[addr_w] = 1'b0;
        // Applied after the clear so a new producer wins over the retiring one.
        if (iss_set)
            busy_d[iss_rd] = 1'b1;

        // A writeback that clears a bit re-claimed in the same cycle nets to zero.
        inc = iss_set && !busy_q[iss_rd];
        dec = wr_eff && busy_q[addr_w] && !(iss_set && (iss_rd == addr_w));

        pend_cnt_d = pend_cnt_q;
        if (inc && !dec)
            pend_cnt_d = pend_cnt_q + 1'b1;
        else if (dec && !inc)
            pend_cnt_d = pend_cnt_q - 1'b1;

        busy_op0 = rd_busy(src_op0, busy_q, we, addr_w);
        busy_op1 = rd_busy(src_op1, busy_q, we, addr_w);
        pend_cnt = pend_cnt_q;
    end

    // Scoreboard state; reset wins over any same-cycle issue or writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file: two combinational read ports with optional
// writeback forwarding, optional hardwired-zero register, and busy scoreboard.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int D_BITS   = D_BITS_DEF,
    parameter int A_BITS   = A_BITS_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [A_BITS-1:0] src_op0,
    input  logic [A_BITS-1:0] src_op1,
    output logic [D_BITS-1:0] data_op0,
    output logic [D_BITS-1:0] data_op1,
    output logic              busy_op0,
    output logic              busy_op1,
    input  logic              we,
    input  logic [A_BITS-1:0] addr_w,
    input  logic [D_BITS-1:0] data,
    input  logic              iss_valid,
    input  logic [A_BITS-1:0] iss_rd,
    output logic              iss_ready,
    output logic [A_BITS:0]   pend_cnt
);
    localparam int                NREGS = 2 ** A_BITS;
    localparam logic [A_BITS-1:0] ZADDR = A_BITS'(ZERO_IDX);

    logic [D_BITS-1:0] regs_q [NREGS];
    logic [D_BITS-1:0] regs_d [NREGS];
    logic              wr_eff;

    // Read-port data with zero register and optional forwarding applied.
    function automatic logic [D_BITS-1:0] rd_data(input logic [A_BITS-1:0] src,
                                                  input logic [D_BITS-1:0] stored,
                                                  input logic              w,
                                                  input logic [A_BITS-1:0] wa,
                                                  input logic [D_BITS-1:0] wd);
        if ((ZERO_REG != 0) && (src == ZADDR))
            return '0;
        if ((BYPASS != 0) && w && (wa == src))
            return wd;
        return stored;
    endfunction

    // Storage next state and combinational read ports.
    always_comb begin
        wr_eff = we && !((ZERO_REG != 0) && (addr_w == ZADDR));
        regs_d = regs_q;
        if (wr_eff)
            regs_d[addr_w] = data;
        data_op0 = rd_data(src_op0, regs_q[src_op0], we, addr_w, data);
        data_op1 = rd_data(src_op1, regs_q[src_op1], we, addr_w, data);
    end

    // Register storage; reset clears every entry and drops any writeback.
    always_ff @(posedge clk) begin
        if (rst)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    rf_scoreboard #(
        .A_BITS   (A_BITS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .src_op0   (src_op0),
        .src_op1   (src_op1),
        .we        (we),
        .addr_w    (addr_w),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_op0  (busy_op0),
        .busy_op1  (busy_op1),
        .iss_ready (iss_ready),
        .pend_cnt  (pend_cnt)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and model-checked bench for regfile_scoreboard; a forwarding
// instance (u_b) and a non-forwarding instance (u_n) share all inputs.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_op0, src_op1, addr_w, iss_rd;
    logic        we, iss_valid;
    logic [31:0] data;

    logic [31:0] b_d0, b_d1, n_d0, n_d1;
    logic        b_b0, b_b1, n_b0, n_b1, b_rdy, n_rdy;
    logic [3:0]  b_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [8];
    logic        m_busy [8];

    always #5 clk = ~clk;

    regfile_scoreboard #(.D_BITS(32), .A_BITS(3), .ZERO_REG(1), .BYPASS(1)) u_b (
        .clk(clk), .rst(rst), .src_op0(src_op0), .src_op1(src_op1),
        .data_op0(b_d0), .data_op1(b_d1), .busy_op0(b_b0), .busy_op1(b_b1),
        .we(we), .addr_w(addr_w), .data(data), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(b_rdy), .pend_cnt(b_cnt));

    regfile_scoreboard #(.D_BITS(32), .A_BITS(3), .ZERO_REG(1), .BYPASS(0)) u_n (
        .clk(clk), .rst(rst), .src_op0(src_op0), .src_op1(src_op1),
        .data_op0(n_d0), .data_op1(n_d1), .busy_op0(n_b0), .busy_op1(n_b1),
        .we(we), .addr_w(addr_w), .data(data), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(n_rdy), .pend_cnt(n_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic int popcnt();
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(m_busy[k]);
        return n;
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; iss_valid = 1'b0;
        src_op0 = '0; src_op1 = '0; addr_w = '0; iss_rd = '0; data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state across all registers
        for (int i = 0; i < 8; i++) begin
            src_op0 = 3'(i); src_op1 = 3'(i);
            settle();
            chk("rst_d0", b_d0, 32'h0);
            chk("rst_d1", b_d1, 32'h0);
            chk("rst_b0", {31'b0, b_b0}, 32'h0);
            chk("rst_b1", {31'b0, b_b1}, 32'h0);
            chk("rst_nd0", n_d0, 32'h0);
        end
        chk("rst_cnt", {28'b0, b_cnt}, 32'h0);

        // Forwarding vs. next-cycle visibility
        tick();
        we = 1'b1; addr_w = 3'd3; data = 32'hDEADBEEF; src_op0 = 3'd3;
        settle();
        chk("byp_same", b_d0, 32'hDEADBEEF);
        chk("nobyp_old", n_d0, 32'h0);
        tick();
        we = 1'b0;
        settle();
        chk("nobyp_next", n_d0, 32'hDEADBEEF);
        chk("byp_next", b_d0, 32'hDEADBEEF);

        // Zero register write is a no-op and never forwarded
        tick();
        we = 1'b1; addr_w = 3'd0; data = 32'h1234; src_op0 = 3'd0;
        settle();
        chk("zero_byp", b_d0, 32'h0);
        tick();
        we = 1'b0;
        settle();
        chk("zero_after", b_d0, 32'h0);
        chk("zero_after_n", n_d0, 32'h0);

        // Issue to zero register: accepted, no count
        iss_valid = 1'b1; iss_rd = 3'd0;
        settle();
        chk("zero_iss_rdy", {31'b0, b_rdy}, 32'h1);
        tick();
        iss_valid = 1'b0;
        settle();
        chk("zero_iss_cnt", {28'b0, b_cnt}, 32'h0);

        // Issue rd=5
        iss_valid = 1'b1; iss_rd = 3'd5;
        settle();
        chk("iss5_rdy", {31'b0, b_rdy}, 32'h1);
        tick();
        iss_valid = 1'b0; src_op1 = 3'd5;
        settle();
        chk("iss5_busy", {31'b0, b_b1}, 32'h1);
        chk("iss5_busy_n", {31'b0, n_b1}, 32'h1);
        chk("iss5_cnt", {28'b0, b_cnt}, 32'h1);

        // WAW stall
        iss_valid = 1'b1; iss_rd = 3'd5;
        settle();
        chk("waw_rdy", {31'b0, b_rdy}, 32'h0);
        tick();
        settle();
        chk("waw_cnt", {28'b0, b_cnt}, 32'h1);

        // Writeback to 5 with simultaneous re-issue to 5
        we = 1'b1; addr_w = 3'd5; data = 32'h0000A5A5;
        settle();
        chk("wbiss_rdy", {31'b0, b_rdy}, 32'h1);
        chk("wbiss_bbyp", {31'b0, b_b1}, 32'h0);
        chk("wbiss_dbyp", b_d1, 32'h0000A5A5);
        chk("wbiss_nbusy", {31'b0, n_b1}, 32'h1);
        tick();
        we = 1'b0; iss_valid = 1'b0;
        settle();
        chk("wbiss_busy", {31'b0, b_b1}, 32'h1);
        chk("wbiss_cnt", {28'b0, b_cnt}, 32'h1);
        chk("wbiss_data", b_d1, 32'h0000A5A5);

        // Plain writeback retires reg 5
        we = 1'b1; addr_w = 3'd5; data = 32'h77;
        tick();
        // Write to a non-busy register leaves the count alone
        addr_w = 3'd4; data = 32'h44;
        tick();
        we = 1'b0;
        settle();
        chk("wb5_cnt", {28'b0, b_cnt}, 32'h0);
        src_op0 = 3'd4;
        settle();
        chk("wb4_data", b_d0, 32'h44);

        // Fill all non-zero registers
        for (int r = 1; r < 8; r++) begin
            iss_valid = 1'b1; iss_rd = 3'(r);
            tick();
        end
        iss_valid = 1'b0;
        settle();
        chk("full_cnt", {28'b0, b_cnt}, 32'h7);
        chk("full_cnt_n", {28'b0, n_cnt}, 32'h7);

        // Reset with a concurrent writeback
        rst = 1'b1; we = 1'b1; addr_w = 3'd2; data = 32'hFFFF;
        tick();
        rst = 1'b0; we = 1'b0;
        settle();
        chk("mrst_cnt", {28'b0, b_cnt}, 32'h0);
        for (int i = 1; i < 8; i++) begin
            src_op0 = 3'(i);
            settle();
            chk("mrst_busy", {31'b0, b_b0}, 32'h0);
            chk("mrst_data", b_d0, 32'h0);
        end

        // Random issue/writeback mix against a reference model
        for (int k = 0; k < 8; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
        for (int c = 0; c < 1000; c++) begin
            logic        exp_rdy;
            logic        fwd0, fwd1;
            we        = ($urandom_range(0, 99) < 45);
            addr_w    = 3'($urandom_range(0, 7));
            data      = $urandom;
            iss_valid = ($urandom_range(0, 99) < 55);
            iss_rd    = 3'($urandom_range(0, 7));
            src_op0   = 3'($urandom_range(0, 7));
            src_op1   = 3'($urandom_range(0, 7));
            settle();
            exp_rdy = iss_valid && (iss_rd == 3'd0 || !m_busy[iss_rd] || (we && addr_w == iss_rd));
            fwd0 = we && (addr_w == src_op0);
            fwd1 = we && (addr_w == src_op1);
            chk("rnd_rdy", {31'b0, b_rdy}, {31'b0, exp_rdy});
            chk("rnd_cnt", {28'b0, b_cnt}, 32'(popcnt()));
            chk("rnd_cnt_n", {28'b0, n_cnt}, 32'(popcnt()));
            chk("rnd_bd0", b_d0, (src_op0 == 3'd0) ? 32'h0 : (fwd0 ? data : m_regs[src_op0]));
            chk("rnd_bd1", b_d1, (src_op1 == 3'd0) ? 32'h0 : (fwd1 ? data : m_regs[src_op1]));
            chk("rnd_nd0", n_d0, (src_op0 == 3'd0) ? 32'h0 : m_regs[src_op0]);
            chk("rnd_bb0", {31'b0, b_b0}, {31'b0, (src_op0 != 3'd0) && !fwd0 && m_busy[src_op0]});
            chk("rnd_nb1", {31'b0, n_b1}, {31'b0, (src_op1 != 3'd0) && m_busy[src_op1]});
            if (we && addr_w != 3'd0) begin
                m_regs[addr_w] = data;
                m_busy[addr_w] = 1'b0;
            end
            if (exp_rdy && iss_rd != 3'd0)
                m_busy[iss_rd] = 1'b1;
            tick();
        end
        we = 1'b0; iss_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
